// File: rtl/test_boot_pkg.sv
// Shared types and constants for the boot sequencer and its watchdog.
package test_boot_pkg;

    typedef enum logic [2:0] {
        HOLD,
        LOAD,
        RELEASE,
        RUN,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        RUNNING = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        TIMEOUT = 2'd3
    } status_e;

    localparam logic [31:0] PASS_CODE = 32'd1;

endpackage

// File: rtl/boot_watchdog.sv
// Saturating run-cycle counter with a combinational timeout against max_cycles.
module boot_watchdog #(
    parameter int CYC_W = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             stop,
    input  logic [CYC_W-1:0] max_cycles,
    output logic [CYC_W-1:0] trace_count,
    output logic             timeout
);

    assign timeout = run && (trace_count >= max_cycles);

    // The final RUN cycle (done or timeout) does not advance the count, so it freezes at the value seen.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trace_count <= '0;
        end else if (run && !stop && !timeout && (trace_count != '1)) begin
            trace_count <= trace_count + 1'b1;
        end
    end

endmodule

// File: rtl/test_boot_sequencer.sv
// Sequences a test run: hold DUT reset, optionally stream an image into SRAM, then run under a watchdog.
module test_boot_sequencer
    import test_boot_pkg::*;
#(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 64,
    parameter int RESET_HOLD = 16,
    parameter int CYC_W      = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              has_image,
    input  logic [CYC_W-1:0]  max_cycles,
    input  logic              img_valid,
    output logic              img_ready,
    input  logic [ADDR_W-1:0] img_addr,
    input  logic [DATA_W-1:0] img_data,
    input  logic              img_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              dut_reset,
    input  logic              done_valid,
    input  logic [31:0]       done_code,
    output logic [CYC_W-1:0]  trace_count,
    output logic [1:0]        status,
    output logic              finished,
    output logic [31:0]       exit_code
);

    localparam int HOLD_W = $clog2(RESET_HOLD + 1);

    state_e            state;
    state_e            state_next;
    logic [HOLD_W-1:0] hold_cnt;
    status_e           status_q;
    logic              xfer;
    logic              running;
    logic              timeout;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= HOLD;
            hold_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == HOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        img_ready  = 1'b0;
        dut_reset  = 1'b1;
        finished   = 1'b0;
        case (state)
            HOLD: begin
                if (hold_cnt == HOLD_W'(RESET_HOLD - 1)) begin
                    state_next = has_image ? LOAD : RELEASE;
                end
            end
            LOAD: begin
                img_ready = 1'b1;
                if (img_valid && img_last) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                state_next = RUN;
            end
            RUN: begin
                dut_reset = 1'b0;
                if (done_valid || timeout) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                dut_reset = 1'b0;
                finished  = 1'b1;
            end
            default: begin
                state_next = HOLD;
            end
        endcase
    end

    assign xfer    = img_valid && img_ready;
    assign running = (state == RUN);

    // One-cycle registered write path; address/data hold their last beat between writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= xfer;
            if (xfer) begin
                mem_addr  <= img_addr;
                mem_wdata <= img_data;
            end
        end
    end

    // A DUT result in the same cycle as the timeout takes priority.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status_q  <= RUNNING;
            exit_code <= '0;
        end else if (running) begin
            if (done_valid) begin
                exit_code <= done_code;
                status_q  <= (done_code == PASS_CODE) ? PASS : FAIL;
            end else if (timeout) begin
                exit_code <= '0;
                status_q  <= TIMEOUT;
            end
        end
    end

    assign status = status_q;

    boot_watchdog #(
        .CYC_W(CYC_W)
    ) u_watchdog (
        .clock      (clock),
        .reset      (reset),
        .run        (running),
        .stop       (done_valid),
        .max_cycles (max_cycles),
        .trace_count(trace_count),
        .timeout    (timeout)
    );

endmodule

// File: tb/tb_test_boot_sequencer.sv
// Scoreboard bench for test_boot_sequencer: SRAM writes checked against a queue filled at each image handshake.
module tb_test_boot_sequencer;

    localparam int ADDR_W     = 20;
    localparam int DATA_W     = 64;
    localparam int RESET_HOLD = 16;
    localparam int CYC_W      = 64;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } wr_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              has_image = 1'b0;
    logic [CYC_W-1:0]  max_cycles = '1;
    logic              img_valid = 1'b0;
    logic              img_ready;
    logic [ADDR_W-1:0] img_addr = '0;
    logic [DATA_W-1:0] img_data = '0;
    logic              img_last = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              dut_reset;
    logic              done_valid = 1'b0;
    logic [31:0]       done_code = '0;
    logic [CYC_W-1:0]  trace_count;
    logic [1:0]        status;
    logic              finished;
    logic [31:0]       exit_code;

    int  compared = 0;
    int  mismatched = 0;
    int  cycle = 0;
    int  writeCount = 0;
    wr_t expQ[$];

    test_boot_sequencer #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RESET_HOLD(RESET_HOLD),
        .CYC_W     (CYC_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .has_image  (has_image),
        .max_cycles (max_cycles),
        .img_valid  (img_valid),
        .img_ready  (img_ready),
        .img_addr   (img_addr),
        .img_data   (img_data),
        .img_last   (img_last),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .dut_reset  (dut_reset),
        .done_valid (done_valid),
        .done_code  (done_code),
        .trace_count(trace_count),
        .status     (status),
        .finished   (finished),
        .exit_code  (exit_code)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Writes must match handshakes in order and appear exactly one cycle later.
    always @(negedge clock) begin
        wr_t e;
        if (mem_we) begin
            writeCount++;
            if (expQ.size() == 0) begin
                checkOutput("mem_unexpected", 64'(mem_we), 64'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("mem_addr", 64'(mem_addr), 64'(e.addr));
                checkOutput("mem_data", mem_wdata, e.data);
                checkOutput("mem_latency", 64'(cycle), 64'(e.cyc + 1));
            end
        end
        if (img_valid && img_ready) begin
            e.addr = img_addr;
            e.data = img_data;
            e.cyc  = cycle;
            expQ.push_back(e);
        end
    end

    task automatic doReset(input logic img, input logic [CYC_W-1:0] maxc);
        reset      = 1'b1;
        has_image  = img;
        max_cycles = maxc;
        img_valid  = 1'b0;
        img_last   = 1'b0;
        done_valid = 1'b0;
        done_code  = '0;
        repeat (3) @(posedge clock);
        #1;
        expQ.delete();
        checkOutput("rst_dut_reset", 64'(dut_reset), 64'd1);
        checkOutput("rst_img_ready", 64'(img_ready), 64'd0);
        checkOutput("rst_mem_we", 64'(mem_we), 64'd0);
        checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 64'd0);
        checkOutput("rst_trace", trace_count, 64'd0);
        checkOutput("rst_status", 64'(status), 64'd0);
        checkOutput("rst_finished", 64'(finished), 64'd0);
        checkOutput("rst_exit", 64'(exit_code), 64'd0);
        reset = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the beat's handshake edge.
    task automatic applyStimulus(input int addr, input logic [63:0] data, input logic last);
        bit done = 0;
        img_valid = 1'b1;
        img_addr  = ADDR_W'(addr);
        img_data  = data;
        img_last  = last;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            if (img_ready) begin
                @(posedge clock);
                #1;
                done = 1;
            end
        end
        if (!done) checkOutput("beat_timeout", 64'(img_ready), 64'd1);
        img_valid = 1'b0;
        img_last  = 1'b0;
    endtask

    task automatic loadBeats(input int count, input logic lastOnEnd);
        for (int i = 0; i < count; i++) begin
            applyStimulus(i, 64'hA0 + 64'(i), lastOnEnd && (i == count - 1));
            if (i < count - 1) begin
                repeat (2) @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic waitCount(input logic [CYC_W-1:0] target);
        for (int i = 0; i < 1000; i++) begin
            @(posedge clock);
            #1;
            if (trace_count == target) break;
        end
        checkOutput("wait_count", trace_count, target);
    endtask

    task automatic pulseDone(input logic [31:0] code);
        done_valid = 1'b1;
        done_code  = code;
        @(posedge clock);
        #1;
        done_valid = 1'b0;
    endtask

    task automatic checkReleaseThenRun();
        checkOutput("release_dut_reset", 64'(dut_reset), 64'd1);
        checkOutput("release_img_ready", 64'(img_ready), 64'd0);
        @(posedge clock);
        #1;
        checkOutput("run_dut_reset", 64'(dut_reset), 64'd0);
        checkOutput("run_trace_start", trace_count, 64'd0);
        checkOutput("run_queue_empty", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        int n;

        // No image: release timing, ignored image beats, pass result.
        doReset(1'b0, '1);
        img_valid = 1'b1;
        img_addr  = ADDR_W'(5);
        img_data  = 64'hDEAD;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock);
            #1;
            n = i;
            if (!dut_reset) break;
        end
        img_valid = 1'b0;
        checkOutput("release_cycle", 64'(n), 64'd17);
        waitCount(100);
        pulseDone(32'd1);
        checkOutput("pass_finished", 64'(finished), 64'd1);
        checkOutput("pass_status", 64'(status), 64'd1);
        checkOutput("pass_exit", 64'(exit_code), 64'd1);
        checkOutput("pass_trace", trace_count, 64'd100);
        repeat (5) @(posedge clock);
        #1;
        checkOutput("pass_trace_frozen", trace_count, 64'd100);
        checkOutput("done_dut_reset", 64'(dut_reset), 64'd0);
        checkOutput("noimg_writes", 64'(writeCount), 64'd0);

        // Four-beat image with valid gaps, then a failing result code.
        writeCount = 0;
        doReset(1'b1, '1);
        loadBeats(4, 1'b1);
        checkReleaseThenRun();
        checkOutput("img_writes", 64'(writeCount), 64'd4);
        waitCount(5);
        pulseDone(32'd7);
        checkOutput("fail_status", 64'(status), 64'd2);
        checkOutput("fail_exit", 64'(exit_code), 64'd7);

        // Timeout at max_cycles; later done_valid has no effect.
        doReset(1'b0, 64'd50);
        for (int i = 0; i < 300 && !finished; i++) begin
            @(posedge clock);
            #1;
        end
        checkOutput("to_finished", 64'(finished), 64'd1);
        checkOutput("to_status", 64'(status), 64'd3);
        checkOutput("to_trace", trace_count, 64'd50);
        checkOutput("to_exit", 64'(exit_code), 64'd0);
        pulseDone(32'd1);
        checkOutput("to_status_held", 64'(status), 64'd3);
        checkOutput("to_exit_held", 64'(exit_code), 64'd0);
        checkOutput("to_trace_held", trace_count, 64'd50);

        // Done and timeout in the same cycle: done wins.
        doReset(1'b0, 64'd20);
        waitCount(20);
        pulseDone(32'd3);
        checkOutput("tie_status", 64'(status), 64'd2);
        checkOutput("tie_exit", 64'(exit_code), 64'd3);
        checkOutput("tie_trace", trace_count, 64'd20);

        // Reset mid-load after three beats, then a full reload.
        writeCount = 0;
        doReset(1'b1, '1);
        loadBeats(3, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midrst_dut_reset", 64'(dut_reset), 64'd1);
        checkOutput("midrst_img_ready", 64'(img_ready), 64'd0);
        checkOutput("midrst_mem_we", 64'(mem_we), 64'd0);
        expQ.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock);
            #1;
            n = i;
            if (img_ready) break;
        end
        checkOutput("midrst_hold_len", 64'(n), 64'd16);
        loadBeats(4, 1'b1);
        checkReleaseThenRun();
        checkOutput("reload_writes", 64'(writeCount), 64'd7);
        waitCount(10);
        pulseDone(32'd1);
        checkOutput("reload_status", 64'(status), 64'd1);
        checkOutput("reload_trace", trace_count, 64'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
